// File: rtl/trace_capture_if.sv
// trace_capture_if: valid/ready drain port carrying {cycle stamp, instruction} trace entries
interface trace_capture_if #(
  parameter int INST_W = 32,
  parameter int CYCLE_CNT_W = 32
);
  logic out_valid;
  logic out_ready;
  logic [CYCLE_CNT_W-1:0] out_cycle;
  logic [INST_W-1:0] out_instr;
  modport master(output out_valid, out_cycle, out_instr, input out_ready);
  modport slave(input out_valid, out_cycle, out_instr, output out_ready);
endinterface

// File: rtl/trace_capture_ctrl.sv
// trace_capture_ctrl: arms, waits for trigger under a watchdog, captures decode trace into a FIFO and drains it.
// Define TRACE_CAPTURE_DROP_CNT_EN to implement the saturating drop_count counter (otherwise tied to 0).
module trace_capture_ctrl #(
  parameter int INST_W = 32,
  parameter int CYCLE_CNT_W = 32,
  parameter int DEPTH = 8,
  parameter int WATCHDOG_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic trigger,
  input  logic test_undone,
  input  logic inst_valid,
  input  logic [INST_W-1:0] instruction,
  input  logic [CYCLE_CNT_W-1:0] cycle_count,
  trace_capture_if.master out_if,
  output logic [2:0] state_o,
  output logic busy,
  output logic overflow,
  output logic timeout,
  output logic [15:0] drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(WATCHDOG_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [CYCLE_CNT_W+INST_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [WW-1:0] wd;
  logic empty, full, push, pop, accept, drop, arm, expire;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign pop = !empty && out_if.out_ready;
  assign push = state == CAPTURE && enable && test_undone && inst_valid;
  assign accept = push && (!full || pop);
  assign drop = push && full && !pop;
  assign arm = state == IDLE && enable;
  assign expire = wd == WW'(WATCHDOG_CYCLES - 1);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = enable ? ARMED : IDLE;
      ARMED:   state_nx = !enable ? IDLE : trigger ? CAPTURE : expire ? DONE : ARMED;
      CAPTURE: state_nx = (!enable || !test_undone) ? DRAIN : CAPTURE;
      DRAIN:   state_nx = empty ? DONE : DRAIN;
      DONE:    state_nx = enable ? DONE : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      wd <= '0;
      overflow <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state <= state_nx;
      wd <= arm ? '0 : state == ARMED ? wd + WW'(1) : wd;
      overflow <= !arm && (overflow || drop);
      timeout <= !arm && (timeout || (state == ARMED && state_nx == DONE));
      wr_ptr <= accept ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count <= count + (AW+1)'(accept) - (AW+1)'(pop);
    end
  end
  // Storage is left unreset; the output mux forces zero while empty.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= {cycle_count, instruction};
  end
`ifdef TRACE_CAPTURE_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_count <= '0;
    else if (arm) drop_count <= '0;
    else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
  end
`else
  assign drop_count = '0;
`endif
  assign out_if.out_valid = !empty;
  assign {out_if.out_cycle, out_if.out_instr} = empty ? '0 : mem[rd_ptr];
  assign state_o = state;
  assign busy = state inside {ARMED, CAPTURE, DRAIN};
endmodule

// File: tb/tb_trace_capture_ctrl.sv
// tb_trace_capture_ctrl: scoreboard bench for trace_capture_ctrl (DEPTH=8, WATCHDOG_CYCLES=10)
module tb_trace_capture_ctrl;
  localparam int DEPTH = 8;
  localparam int WD = 10;
  logic clk = 0, rst = 1, enable = 0, trigger = 0, test_undone = 1, inst_valid = 0;
  logic [31:0] instruction = 0, cycle_count = 0;
  logic [2:0] state_o;
  logic busy, overflow, timeout;
  logic [15:0] drop_count;
  logic [63:0] q[$];
  int checks = 0, errors = 0, m_drops = 0;
  bit capturing = 0;
  trace_capture_if #(.INST_W(32), .CYCLE_CNT_W(32)) oif();
  trace_capture_ctrl #(.INST_W(32), .CYCLE_CNT_W(32), .DEPTH(DEPTH), .WATCHDOG_CYCLES(WD)) dut (
    .clk(clk), .rst(rst), .enable(enable), .trigger(trigger), .test_undone(test_undone),
    .inst_valid(inst_valid), .instruction(instruction), .cycle_count(cycle_count),
    .out_if(oif), .state_o(state_o), .busy(busy), .overflow(overflow), .timeout(timeout),
    .drop_count(drop_count)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Compare the head against the scoreboard, apply this cycle's pop/push to the model, then clock.
  task automatic tick();
    if (q.size() == 0) begin
      chk("empty_valid", 64'(oif.out_valid), 0);
      chk("empty_data", {oif.out_cycle, oif.out_instr}, 0);
    end else begin
      chk("valid", 64'(oif.out_valid), 1);
      chk("head", {oif.out_cycle, oif.out_instr}, q[0]);
    end
    if (oif.out_ready && q.size() > 0) void'(q.pop_front());
    if (capturing && enable && test_undone && inst_valid) begin
      if (q.size() < DEPTH) q.push_back({cycle_count, instruction});
      else m_drops++;
    end
    @(posedge clk);
    #1;
    cycle_count++;
  endtask
  task automatic arm();
    m_drops = 0;
    enable = 1;
    tick();
    chk("armed", 64'(state_o), 1);
    chk("armed_busy", 64'(busy), 1);
  endtask
  task automatic trig();
    trigger = 1;
    tick();
    trigger = 0;
    chk("capture", 64'(state_o), 2);
    capturing = 1;
  endtask
  task automatic finish_cap();
    inst_valid = 0;
    test_undone = 0;
    tick();
    capturing = 0;
    chk("drain", 64'(state_o), 3);
    oif.out_ready = 1;
    for (int i = 0; i < 64 && state_o != 3'd4; i++) tick();
    chk("done", 64'(state_o), 4);
    chk("drained", 64'(q.size()), 0);
    test_undone = 1;
    enable = 0;
    tick();
    chk("idle", 64'(state_o), 0);
    chk("idle_busy", 64'(busy), 0);
  endtask
  task automatic chk_drops();
`ifdef TRACE_CAPTURE_DROP_CNT_EN
    chk("drop_count", 64'(drop_count), 64'(m_drops));
`else
    chk("drop_count", 64'(drop_count), 0);
`endif
  endtask
  initial begin
    oif.out_ready = 0;
    #3;
    chk("rst_state", 64'(state_o), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_ovf", 64'(overflow), 0);
    chk("rst_to", 64'(timeout), 0);
    chk("rst_drop", 64'(drop_count), 0);
    chk("rst_valid", 64'(oif.out_valid), 0);
    @(posedge clk);
    #1;
    rst = 0;
    // basic capture; the trigger cycle carries a valid word that must not be captured
    oif.out_ready = 1;
    arm();
    inst_valid = 1;
    instruction = 32'hdeadbeef;
    trig();
    for (int i = 0; i < 4; i++) begin
      instruction = 32'h13 + 32'(i);
      tick();
    end
    finish_cap();
    // enable drop while armed
    arm();
    enable = 0;
    tick();
    chk("abort_idle", 64'(state_o), 0);
    // watchdog expiry
    arm();
    for (int i = 1; i < WD; i++) tick();
    chk("pre_to_state", 64'(state_o), 1);
    chk("pre_to", 64'(timeout), 0);
    tick();
    chk("to_state", 64'(state_o), 4);
    chk("to_flag", 64'(timeout), 1);
    enable = 0;
    tick();
    chk("to_idle", 64'(state_o), 0);
    chk("to_sticky", 64'(timeout), 1);
    // trigger on the expiry edge wins
    arm();
    chk("to_cleared", 64'(timeout), 0);
    for (int i = 1; i < WD; i++) tick();
    trigger = 1;
    tick();
    trigger = 0;
    chk("trig_wins", 64'(state_o), 2);
    chk("trig_no_to", 64'(timeout), 0);
    capturing = 1;
    finish_cap();
    // overflow: 11 pushes into 8 entries with no drain
    oif.out_ready = 0;
    arm();
    trig();
    inst_valid = 1;
    for (int i = 0; i < 11; i++) begin
      instruction = 32'h100 + 32'(i);
      tick();
    end
    inst_valid = 0;
    chk("ovf_flag", 64'(overflow), 1);
    chk_drops();
    finish_cap();
    // full buffer with simultaneous push and pop
    oif.out_ready = 0;
    arm();
    chk("ovf_cleared", 64'(overflow), 0);
    trig();
    inst_valid = 1;
    for (int i = 0; i < 8; i++) begin
      instruction = 32'h200 + 32'(i);
      tick();
    end
    oif.out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      instruction = 32'h300 + 32'(i);
      tick();
    end
    inst_valid = 0;
    chk("full_pp_ovf", 64'(overflow), 0);
    chk_drops();
    finish_cap();
    // random backpressure
    arm();
    trig();
    for (int i = 0; i < 40; i++) begin
      inst_valid = 1'($urandom_range(0, 1));
      instruction = $urandom;
      oif.out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    chk("bp_ovf", 64'(overflow), 64'(m_drops > 0));
    chk_drops();
    finish_cap();
    // asynchronous reset mid-capture with 3 entries buffered
    oif.out_ready = 0;
    arm();
    trig();
    inst_valid = 1;
    for (int i = 0; i < 3; i++) begin
      instruction = 32'h400 + 32'(i);
      tick();
    end
    inst_valid = 0;
    chk("pre_rst_valid", 64'(oif.out_valid), 1);
    #2 rst = 1;
    #1;
    chk("mid_rst_state", 64'(state_o), 0);
    chk("mid_rst_valid", 64'(oif.out_valid), 0);
    chk("mid_rst_ovf", 64'(overflow), 0);
    chk("mid_rst_to", 64'(timeout), 0);
    chk("mid_rst_drop", 64'(drop_count), 0);
    chk("mid_rst_busy", 64'(busy), 0);
    q.delete();
    capturing = 0;
    enable = 0;
    @(posedge clk);
    #1;
    rst = 0;
    tick();
    chk("post_rst_state", 64'(state_o), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/trace_capture_ctrl.md
# trace_capture_ctrl

Synthesizable capture controller that sequences recording of decoded instructions from the Decode stage into an on-chip trace buffer. It arms on `enable`, waits for `trigger` under a watchdog, captures `{cycle_count, instruction}` pairs while the test runs, then drains the buffer to a downstream logger over a valid/ready port. It replaces ad-hoc simulation-only tracking with an RTL block that can also be used on FPGA builds of the core.

## Interface
- `INST_W`, 32, instruction width (XLEN).
- `CYCLE_CNT_W`, 32, cycle-stamp width.
- `DEPTH`, 8, trace buffer entries; power of two, at least 2.
- `WATCHDOG_CYCLES`, 1000, ARMED-state cycles before timeout; at least 1.

- `clk`  in  1  single clock; all state is updated on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  arms the controller; deassertion aborts or acknowledges completion.
- `trigger`  in  1  capture start qualifier.
- `test_undone`  in  1  1 while the test runs; 0 ends capture.
- `inst_valid`  in  1  Decode presents a valid instruction this cycle.
- `instruction`  in  INST_W  decoded instruction word.
- `cycle_count`  in  CYCLE_CNT_W  free-running cycle stamp.
- `out_valid`  out  1  buffer head valid.
- `out_ready`  in  1  downstream accepts the head.
- `out_cycle`  out  CYCLE_CNT_W  head cycle stamp.
- `out_instr`  out  INST_W  head instruction.
- `state_o`  out  3  FSM state: IDLE=0, ARMED=1, CAPTURE=2, DRAIN=3, DONE=4.
- `busy`  out  1  state is ARMED, CAPTURE or DRAIN.
- `overflow`  out  1  sticky; at least one entry dropped.
- `timeout`  out  1  sticky; the watchdog expired.
- `drop_count`  out  16  dropped-entry count, saturating at 0xFFFF.

## Operation
- **IDLE:** `enable`=1 moves to ARMED and clears `overflow`, `timeout`, `drop_count` and the watchdog.
- **ARMED:** the watchdog increments each cycle.
  - `trigger`=1 moves to CAPTURE.
  - If the watchdog equals WATCHDOG_CYCLES-1 and `trigger`=0, the state moves to DONE and `timeout` is set. If both happen in the same cycle, `trigger` wins.
  - `enable`=0 returns to IDLE and takes priority over everything else.
- **CAPTURE:** push `{cycle_count, instruction}` in each cycle with `inst_valid`=1 and `test_undone`=1.
  - `test_undone`=0 or `enable`=0 moves to DRAIN; nothing is pushed in that cycle.
  - The trigger cycle itself is not captured.
- **DRAIN:** no pushes. Move to DONE in the cycle the buffer is empty, including an empty buffer on entry.
- **DONE:** hold until `enable`=0, then go to IDLE. The buffer is always empty here.
- **Buffer:** circular, with pointers of log2(DEPTH) bits that wrap naturally and an occupancy count of log2(DEPTH)+1 bits.
  - Pop occurs on `out_valid` && `out_ready`.
  - Push when full with no pop in the same cycle: the entry is dropped, `overflow` is set, and `drop_count` is incremented (saturating).
  - Push when full with a pop in the same cycle: accepted, and the count is unchanged.
  - Pop and push when empty: the push is accepted. The pop is ignored because `out_valid` is 0.
- **Output port:** `out_valid` = !empty. `out_cycle` and `out_instr` are first-word-fall-through from head storage and stay stable while `out_valid`=1 and `out_ready`=0.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- **Reset:** state IDLE; all outputs 0; pointers and count 0. Storage contents are don't-care, but `out_cycle` and `out_instr` read 0 while empty.
- **IDLE to ARMED:** 1 cycle after `enable` is sampled high.
- **Trigger latency:** `trigger` sampled at edge N gives `state_o`=CAPTURE after edge N; the first capturable sample is at edge N+1.
- **Push latency:** a push at edge N gives `out_valid`=1 after edge N, so the entry is visible in cycle N+1.
- **Watchdog:** with `enable` high at edge E, expiry is at edge E+WATCHDOG_CYCLES and `timeout` reads 1 after it.
- **Reset mid-operation:** asynchronous return to the reset state; buffered entries are lost.

## Configuration
- `TRACE_CAPTURE_DROP_CNT_EN`
  - Defined: the 16-bit saturating `drop_count` counter is implemented as specified.
  - Undefined: the counter logic is removed and `drop_count` is tied to 0. `overflow` behaviour is unchanged.

## Test plan
- **Reset:** assert `rst` mid-CAPTURE with 3 entries buffered -> `state_o`=0, `out_valid`=0, `overflow`=0, `timeout`=0, `drop_count`=0 immediately.
- **Basic capture:** `enable`, then `trigger`, then 4 valid instructions 0x00000013..0x00000016, then `test_undone`=0, with `out_ready`=1 -> 4 entries out in order with matching cycle stamps, then DRAIN then DONE; `enable`=0 -> IDLE.
- **Timeout:** WATCHDOG_CYCLES=10, `enable` with no `trigger` -> `timeout`=1 and `state_o`=4 after exactly 10 edges; `trigger` on the 10th edge -> CAPTURE instead and `timeout`=0.
- **Overflow:** DEPTH=8, `out_ready`=0, 11 valid pushes -> 8 entries kept (first 8), `overflow`=1, `drop_count`=3. With the macro undefined -> `drop_count`=0.
- **Full with simultaneous push/pop:** full buffer, `out_ready`=1 and a push each cycle for 20 cycles -> no drops, FIFO order preserved, and the pointers wrap at least twice.
- **Backpressure:** toggle `out_ready` randomly -> head data stays stable while stalled; no entry is lost or duplicated.
